// File: rtl/oled_frame_ctrl.sv
// SSD1306 128x64 OLED sequencer: hardware reset pulse, fixed init command list,
// then full-frame refreshes streamed from the frame buffer through the SPI byte serializer.
module oled_frame_ctrl #(
  parameter int unsigned RST_LOW_CYC  = 10000,
  parameter int unsigned RST_WAIT_CYC = 10000,
  parameter int unsigned FB_BYTES     = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_req,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       init_done,
  output logic [9:0] fb_addr,
  input  logic [7:0] fb_data,
  output logic [7:0] spi_byte,
  output logic       spi_dc,
  output logic       spi_start,
  input  logic       spi_busy,
  output logic       io_reset
);

  localparam logic [3:0] StRstLow  = 4'd0;
  localparam logic [3:0] StRstWait = 4'd1;
  localparam logic [3:0] StIdle    = 4'd2;
  localparam logic [3:0] StFetch   = 4'd3;
  localparam logic [3:0] StLoad    = 4'd4;
  localparam logic [3:0] StSend    = 4'd5;
  localparam logic [3:0] StAck     = 4'd6;
  localparam logic [3:0] StDone    = 4'd7;

  // Command ROM: entries 0..24 are the init list, 25..30 the per-frame window setup.
  localparam logic [4:0]  InitLast = 5'd24;
  localparam logic [4:0]  WinFirst = 5'd25;
  localparam logic [4:0]  WinLast  = 5'd30;
  localparam logic [9:0]  AddrLast = 10'(FB_BYTES - 1);
  localparam logic [31:0] LowLast  = 32'(RST_LOW_CYC - 1);
  localparam logic [31:0] WaitLast = 32'(RST_WAIT_CYC - 1);

  function automatic logic [7:0] cmd_rom(input logic [4:0] idx);
    logic [7:0] b;
    case (idx)
      5'd0:    b = 8'hAE;
      5'd1:    b = 8'hD5;
      5'd2:    b = 8'h80;
      5'd3:    b = 8'hA8;
      5'd4:    b = 8'h3F;
      5'd5:    b = 8'hD3;
      5'd6:    b = 8'h00;
      5'd7:    b = 8'h40;
      5'd8:    b = 8'h8D;
      5'd9:    b = 8'h14;
      5'd10:   b = 8'h20;
      5'd11:   b = 8'h00;
      5'd12:   b = 8'hA1;
      5'd13:   b = 8'hC8;
      5'd14:   b = 8'hDA;
      5'd15:   b = 8'h12;
      5'd16:   b = 8'h81;
      5'd17:   b = 8'hCF;
      5'd18:   b = 8'hD9;
      5'd19:   b = 8'hF1;
      5'd20:   b = 8'hDB;
      5'd21:   b = 8'h40;
      5'd22:   b = 8'hA4;
      5'd23:   b = 8'hA6;
      5'd24:   b = 8'hAF;
      5'd25:   b = 8'h21;
      5'd26:   b = 8'h00;
      5'd27:   b = 8'h7F;
      5'd28:   b = 8'h22;
      5'd29:   b = 8'h00;
      5'd30:   b = 8'h07;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  logic [3:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic [9:0]  addr_q, addr_d;
  logic        pending_q, pending_d;
  logic        init_done_q, init_done_d;
  logic        frame_busy_q, frame_busy_d;
  logic        frame_done_q, frame_done_d;
  logic        spi_start_q, spi_start_d;
  logic [7:0]  spi_byte_q, spi_byte_d;
  logic        spi_dc_q, spi_dc_d;
  logic        io_reset_q, io_reset_d;
  logic        load_cmd;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    pending_d    = pending_q;
    init_done_d  = init_done_q;
    frame_busy_d = frame_busy_q;
    frame_done_d = 1'b0;
    spi_start_d  = 1'b0;
    spi_byte_d   = spi_byte_q;
    spi_dc_d     = spi_dc_q;
    io_reset_d   = io_reset_q;
    load_cmd     = 1'b0;

    // Requests outside IDLE are remembered, including one landing on the last byte.
    if (frame_req && (state_q != StIdle)) pending_d = 1'b1;

    case (state_q)
      StRstLow: begin
        if (cnt_q == LowLast) begin
          cnt_d      = '0;
          io_reset_d = 1'b1;
          state_d    = StRstWait;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StRstWait: begin
        if (cnt_q == WaitLast) begin
          cnt_d    = '0;
          idx_d    = '0;
          load_cmd = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StIdle: begin
        if (frame_req || pending_q) begin
          pending_d    = 1'b0;
          frame_busy_d = 1'b1;
          addr_d       = '0;
          idx_d        = WinFirst;
          load_cmd     = 1'b1;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        spi_byte_d  = fb_data;
        spi_dc_d    = 1'b1;
        spi_start_d = 1'b1;
        state_d     = StSend;
      end
      StSend: state_d = StAck;
      StAck: begin
        if (spi_busy) state_d = StDone;
      end
      StDone: begin
        if (!spi_busy) begin
          if (!init_done_q) begin
            if (idx_q == InitLast) begin
              init_done_d = 1'b1;
              state_d     = StIdle;
            end else begin
              idx_d    = idx_q + 5'd1;
              load_cmd = 1'b1;
            end
          end else if (!spi_dc_q) begin
            if (idx_q == WinLast) begin
              state_d = StFetch;
            end else begin
              idx_d    = idx_q + 5'd1;
              load_cmd = 1'b1;
            end
          end else if (addr_q == AddrLast) begin
            frame_done_d = 1'b1;
            frame_busy_d = 1'b0;
            state_d      = StIdle;
          end else begin
            addr_d  = addr_q + 10'd1;
            state_d = StFetch;
          end
        end
      end
      default: state_d = StRstLow;
    endcase

    if (load_cmd) begin
      spi_byte_d  = cmd_rom(idx_d);
      spi_dc_d    = 1'b0;
      spi_start_d = 1'b1;
      state_d     = StSend;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRstLow;
      cnt_q        <= '0;
      idx_q        <= '0;
      addr_q       <= '0;
      pending_q    <= 1'b0;
      init_done_q  <= 1'b0;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      spi_start_q  <= 1'b0;
      spi_byte_q   <= '0;
      spi_dc_q     <= 1'b0;
      io_reset_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      pending_q    <= pending_d;
      init_done_q  <= init_done_d;
      frame_busy_q <= frame_busy_d;
      frame_done_q <= frame_done_d;
      spi_start_q  <= spi_start_d;
      spi_byte_q   <= spi_byte_d;
      spi_dc_q     <= spi_dc_d;
      io_reset_q   <= io_reset_d;
    end
  end

  assign frame_busy = frame_busy_q;
  assign frame_done = frame_done_q;
  assign init_done  = init_done_q;
  assign fb_addr    = addr_q;
  assign spi_byte   = spi_byte_q;
  assign spi_dc     = spi_dc_q;
  assign spi_start  = spi_start_q;
  assign io_reset   = io_reset_q;

endmodule

// File: tb/tb_oled_frame_ctrl.sv
// Bench for oled_frame_ctrl: random-latency serializer and frame buffer models, with the
// expected byte stream derived from the command lists and frame buffer contents.
module tb_oled_frame_ctrl;

  localparam int FbBytes  = 1024;
  localparam int FrameLen = 6 + FbBytes;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_req;
  logic       frame_busy;
  logic       frame_done;
  logic       init_done;
  logic [9:0] fb_addr;
  logic [7:0] fb_data;
  logic [7:0] spi_byte;
  logic       spi_dc;
  logic       spi_start;
  logic       spi_busy;
  logic       io_reset;

  oled_frame_ctrl #(
    .RST_LOW_CYC (4),
    .RST_WAIT_CYC(4),
    .FB_BYTES    (FbBytes)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_req (frame_req),
    .frame_busy(frame_busy),
    .frame_done(frame_done),
    .init_done (init_done),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .spi_byte  (spi_byte),
    .spi_dc    (spi_dc),
    .spi_start (spi_start),
    .spi_busy  (spi_busy),
    .io_reset  (io_reset)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] init_rom [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                                8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
                                8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
  logic [7:0] win_rom [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
  logic [7:0] fb_mem [FbBytes];
  logic [9:0] addr_lat = '0;

  int n_chk = 0;
  int n_pass = 0;
  int pos = 0;           // starts seen since the last reset
  int last_start = 0;
  bit have_last = 0;
  int last_fall = 0;
  int first_start_cyc = 0;
  int io_rise_cyc = 0;
  int done_cnt = 0;
  bit prev_done = 0;
  bit mutate_en = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Start p after reset: 25 init commands, then repeating frames of 6 window commands + data.
  function automatic void exp_stream(input int p, output logic [7:0] b, output logic d,
                                     output int i);
    int q;
    i = 0;
    if (p < 25) begin
      b = init_rom[p];
      d = 1'b0;
    end else begin
      q = (p - 25) % FrameLen;
      if (q < 6) begin
        b = win_rom[q];
        d = 1'b0;
      end else begin
        i = q - 6;
        b = fb_mem[i];
        d = 1'b1;
      end
    end
  endfunction

  task automatic serializer();
    logic [7:0] b, eb;
    logic       d, ed;
    int         ei, n;
    bit         hit, aborted;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pos       = 0;
        have_last = 0;
      end else if (spi_start) begin
        b = spi_byte;
        d = spi_dc;
        exp_stream(pos, eb, ed, ei);
        check("spi_byte", b, eb);
        check("spi_dc", d, ed);
        check("init_done_at_start", init_done, pos >= 25);
        if (ed) check("fb_addr_at_start", fb_addr, ei);
        if (have_last) check("start_gap_ge3", (cyc - last_start) >= 3, 1);
        if (pos == 0) first_start_cyc = cyc;
        last_start = cyc;
        have_last  = 1;
        pos++;
        n = int'($urandom_range(1, 6));
        @(negedge clk);
        check("start_one_cycle", spi_start, 0);
        spi_busy = 1'b1;
        hit      = 0;
        aborted  = !rst_n;
        repeat (n) begin
          @(negedge clk);
          if (spi_start) hit = 1;
          if (!rst_n) aborted = 1;
        end
        if (!aborted) begin
          check("hold_byte", spi_byte, b);
          check("hold_dc", spi_dc, d);
          check("no_start_while_busy", hit, 0);
        end
        spi_busy  = 1'b0;
        last_fall = cyc;
      end
    end
  endtask

  // Synchronous-read frame buffer: data follows the address by one cycle.
  task automatic fb_model();
    forever begin
      @(negedge clk);
      fb_data  = fb_mem[addr_lat];
      addr_lat = fb_addr;
    end
  endtask

  task automatic done_monitor();
    forever begin
      @(negedge clk);
      if (prev_done) check("done_single_pulse", frame_done, 0);
      if (frame_done) begin
        done_cnt++;
        check("busy_low_at_done", frame_busy, 0);
      end
      prev_done = frame_done;
    end
  endtask

  // Rewrites bytes well ahead of the current fetch so each must be sampled live.
  task automatic mutator();
    int a, j;
    forever begin
      repeat ($urandom_range(20, 60)) @(negedge clk);
      if (mutate_en && frame_busy && fb_addr < 10'd1000) begin
        a = int'(fb_addr);
        j = a + 5 + int'($urandom_range(0, 1018 - a));
        fb_mem[j] = 8'($urandom);
      end
    end
  endtask

  task automatic pulse_req();
    frame_req = 1'b1;
    @(negedge clk); #1;
    frame_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target);
    int k = 0;
    while (done_cnt < target && k < 20000) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, done_cnt >= target, 1);
  endtask

  task automatic wait_init(input string tag);
    int k = 0;
    while (!init_done && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, init_done, 1);
  endtask

  task automatic release_reset(input string tag);
    int n = 0;
    rst_n = 1'b1;
    while (!io_reset && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    io_rise_cyc = cyc;
    check(tag, n, 4);
  endtask

  task automatic outputs_zero(input string p);
    check({p, "_io_reset"}, io_reset, 0);
    check({p, "_spi_start"}, spi_start, 0);
    check({p, "_spi_byte"}, spi_byte, 0);
    check({p, "_spi_dc"}, spi_dc, 0);
    check({p, "_frame_busy"}, frame_busy, 0);
    check({p, "_frame_done"}, frame_done, 0);
    check({p, "_init_done"}, init_done, 0);
    check({p, "_fb_addr"}, fb_addr, 0);
  endtask

  initial begin
    int k;
    rst_n     = 1'b1;
    frame_req = 1'b0;
    spi_busy  = 1'b0;
    fb_data   = '0;
    for (int i = 0; i < FbBytes; i++) fb_mem[i] = 8'(i);
    fork
      serializer();
      fb_model();
      done_monitor();
      mutator();
    join_none

    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    outputs_zero("reset");

    // Reset timing, with a request during the reset wait that must survive until IDLE.
    release_reset("io_reset_low_cycles");
    @(negedge clk); #1;
    pulse_req();
    wait_init("init_timeout");
    check("init_start_count", pos, 25);
    check("init_done_after_last_busy", cyc - last_fall, 1);
    check("first_start_delay", first_start_cyc - io_rise_cyc, 4);
    @(negedge clk); #1;
    check("early_req_frame_start", frame_busy, 1);
    wait_done("frame1_timeout", 1);
    repeat (40) @(negedge clk);
    #1;
    check("frame1_done_count", done_cnt, 1);
    check("frame1_idle_after", frame_busy, 0);
    check("frame1_stream_len", pos, 25 + FrameLen);

    // Three requests inside one frame merge into a single extra frame.
    for (int i = 0; i < FbBytes; i++) fb_mem[i] = 8'($urandom);
    mutate_en = 1;
    pulse_req();
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(200, 1000)) @(negedge clk);
      #1;
      check("merge_req_in_frame", frame_busy, 1);
      pulse_req();
    end
    wait_done("merge_timeout", 3);
    repeat (40) @(negedge clk);
    #1;
    check("merge_done_count", done_cnt, 3);
    check("merge_idle_after", frame_busy, 0);
    check("merge_stream_len", pos, 25 + 3 * FrameLen);

    // Request on the last byte's completion, then a request in the frame_done cycle.
    pulse_req();
    k = 0;
    while (!(spi_dc && fb_addr == 10'(FbBytes - 1) && spi_busy) && k < 20000) begin
      @(negedge clk); #1;
      k++;
    end
    check("last_byte_seen", spi_busy, 1);
    k = 0;
    while (spi_busy && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    frame_req = 1'b1;
    @(negedge clk); #1;
    frame_req = 1'b0;
    wait_done("endreq_frame_timeout", 4);
    @(negedge clk); #1;
    check("pending_restarts_next_cycle", frame_busy, 1);
    wait_done("chained_frame_timeout", 5);
    check("req_with_frame_done", frame_done, 1);
    frame_req = 1'b1;
    @(negedge clk); #1;
    frame_req = 1'b0;
    wait_done("donereq_frame_timeout", 6);
    repeat (40) @(negedge clk);
    #1;
    check("coincide_done_count", done_cnt, 6);
    check("coincide_idle_after", frame_busy, 0);
    check("coincide_stream_len", pos, 25 + 6 * FrameLen);

    // Reset in the middle of data byte 500.
    mutate_en = 0;
    pulse_req();
    k = 0;
    while (!(spi_dc && fb_addr == 10'd500 && spi_busy) && k < 20000) begin
      @(negedge clk); #1;
      k++;
    end
    check("abort_point_seen", fb_addr, 500);
    rst_n = 1'b0;
    #1;
    outputs_zero("abort");
    repeat (10) @(negedge clk);
    #1;
    release_reset("abort_io_reset_low_cycles");
    wait_init("abort_init_timeout");
    check("abort_init_start_count", pos, 25);
    check("abort_first_start_delay", first_start_cyc - io_rise_cyc, 4);
    repeat (40) @(negedge clk);
    #1;
    check("abort_no_frame_done", done_cnt, 6);
    check("abort_no_pending_frame", frame_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
